// File: rtl/hella_cache_master_arb_pkg.sv
// Shared types and constants for the HellaCache master arbiter.
package hella_cache_master_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_S1,
    S_S2,
    S_BACKOFF
  } arb_state_e;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  localparam int BACKOFF_CYCLES = 2;
  localparam int CMD_W          = 5;
  localparam int TYP_W          = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hella_cache_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last winner.
module hella_cache_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    found       = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_grant_i) + off) % N);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hella_cache_master_arb.sv
// Shares one HellaCache port among NUM_REQ requesters; source index rides in
// the downstream tag and nacks are replayed here so requesters never see them.
module hella_cache_master_arb
  import hella_cache_master_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 2,
  parameter  int NUM_ADDR_BITS = 32,
  parameter  int NUM_DATA_BITS = 32,
  parameter  int NUM_TAG_BITS  = 7,
  localparam int SRC_BITS      = $clog2(NUM_REQ),
  localparam int MASK_W        = NUM_DATA_BITS / 8,
  localparam int DTAG_W        = SRC_BITS + NUM_TAG_BITS
) (
  input  logic                                         clock_i,
  input  logic                                         reset_i,
  input  logic [NUM_REQ-1:0]                           in_req_valid_i,
  output logic [NUM_REQ-1:0]                           in_req_ready_o,
  input  logic [NUM_REQ-1:0][NUM_ADDR_BITS-1:0]        in_req_addr_i,
  input  logic [NUM_REQ-1:0][NUM_TAG_BITS-1:0]         in_req_tag_i,
  input  logic [NUM_REQ-1:0][CMD_W-1:0]                in_req_cmd_i,
  input  logic [NUM_REQ-1:0][TYP_W-1:0]                in_req_typ_i,
  input  logic [NUM_REQ-1:0][NUM_DATA_BITS-1:0]        in_req_data_i,
  input  logic [NUM_REQ-1:0][MASK_W-1:0]               in_req_mask_i,
  output logic [NUM_REQ-1:0]                           in_rsp_valid_o,
  output logic [NUM_TAG_BITS-1:0]                      in_rsp_tag_o,
  output logic [TYP_W-1:0]                             in_rsp_typ_o,
  output logic [NUM_DATA_BITS-1:0]                     in_rsp_data_o,
  output logic                                         req_valid_o,
  input  logic                                         req_ready_i,
  output logic [NUM_ADDR_BITS-1:0]                     req_addr_o,
  output logic [DTAG_W-1:0]                            req_tag_o,
  output logic [CMD_W-1:0]                             req_cmd_o,
  output logic [TYP_W-1:0]                             req_typ_o,
  output logic [NUM_DATA_BITS-1:0]                     req_data_o,
  output logic [MASK_W-1:0]                            req_data_mask_o,
  output logic                                         req_kill_o,
  input  logic                                         rsp_valid_i,
  input  logic                                         rsp_nack_i,
  input  logic [DTAG_W-1:0]                            rsp_tag_i,
  input  logic [TYP_W-1:0]                             rsp_typ_i,
  input  logic [NUM_DATA_BITS-1:0]                     rsp_data_i,
  output logic [15:0]                                  nack_count_o
);

  typedef struct packed {
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [DTAG_W-1:0]        tag;
    logic [CMD_W-1:0]         cmd;
    logic [TYP_W-1:0]         typ;
    logic [NUM_DATA_BITS-1:0] data;
    logic [MASK_W-1:0]        mask;
  } hold_t;

  localparam logic [1:0] BO_LAST = 2'(BACKOFF_CYCLES - 1);

  arb_state_e          state_q, state_d;
  hold_t               hold_q, hold_d;
  logic [SRC_BITS-1:0] last_q, last_d;
  logic [15:0]         nack_q, nack_d;
  logic [1:0]          bo_q, bo_d;

  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [SRC_BITS-1:0] gnt_idx;
  logic                gnt_valid;

  // A nacked S2 must not grant: the held request is about to be replayed.
  assign arb_en = ~reset_i & ((state_q == S_IDLE) | ((state_q == S_S2) & ~rsp_nack_i));

  hella_cache_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i        (in_req_valid_i),
    .last_grant_i (last_q),
    .en_i         (arb_en),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  assign in_req_ready_o = gnt;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    nack_d  = nack_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE:    if (gnt_valid) state_d = S_ISSUE;
      S_ISSUE:   if (req_ready_i) state_d = S_S1;
      S_S1:      state_d = S_S2;
      S_S2: begin
        if (rsp_nack_i) begin
          state_d = S_BACKOFF;
          bo_d    = '0;
          nack_d  = sat_inc16(nack_q);
        end else if (gnt_valid) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (bo_q == BO_LAST) state_d = S_ISSUE;
        else                 bo_d    = bo_q + 2'd1;
      end
      default:   state_d = S_IDLE;
    endcase
    if (gnt_valid) begin
      hold_d = '{addr: in_req_addr_i[gnt_idx],
                 tag:  {gnt_idx, in_req_tag_i[gnt_idx]},
                 cmd:  in_req_cmd_i[gnt_idx],
                 typ:  in_req_typ_i[gnt_idx],
                 data: in_req_data_i[gnt_idx],
                 mask: in_req_mask_i[gnt_idx]};
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      last_q  <= SRC_BITS'(NUM_REQ - 1);
      nack_q  <= '0;
      bo_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      nack_q  <= nack_d;
      bo_q    <= bo_d;
    end
  end

  assign req_valid_o     = (state_q == S_ISSUE);
  assign req_addr_o      = hold_q.addr;
  assign req_tag_o       = hold_q.tag;
  assign req_cmd_o       = hold_q.cmd;
  assign req_typ_o       = hold_q.typ;
  assign req_data_o      = hold_q.data;
  assign req_data_mask_o = hold_q.mask;
  assign req_kill_o      = 1'b0;
  assign nack_count_o    = nack_q;

  // Response demux is independent of the FSM; out-of-range sources match no lane.
  logic [SRC_BITS-1:0] rsp_src;
  assign rsp_src       = rsp_tag_i[DTAG_W-1 -: SRC_BITS];
  assign in_rsp_tag_o  = rsp_tag_i[NUM_TAG_BITS-1:0];
  assign in_rsp_typ_o  = rsp_typ_i;
  assign in_rsp_data_o = rsp_data_i;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign in_rsp_valid_o[i] = rsp_valid_i & ~reset_i & (rsp_src == SRC_BITS'(i));
  end

endmodule
